// File: rtl/rv32e_alu_regfile_pkg.sv
// Shared constants for the RV32E execute-stage datapath: widths, ALU op codes
// ({funct7[5], funct3}) and the branch-compare aliases that reuse the a-b path.
package rv32e_alu_regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  // BR_GE shares its encoding with ALU_SRA, so the ALU treats it as a shift.
  localparam logic [3:0] BR_EQ  = 4'b1000;
  localparam logic [3:0] BR_NE  = 4'b1001;
  localparam logic [3:0] BR_LT  = 4'b1100;
  localparam logic [3:0] BR_GE  = 4'b1101;
  localparam logic [3:0] BR_LTU = 4'b1110;
  localparam logic [3:0] BR_GEU = 4'b1111;

endpackage

// File: rtl/rv32e_alu_regfile_if.sv
// Decode/writeback/execute bus of the RV32E datapath. The pipeline drives it
// as master; the register file + ALU block is the slave.
interface rv32e_alu_regfile_if;
  import rv32e_alu_regfile_pkg::*;

  logic [REG_ADDR_W-1:0] rs1_addr;
  logic [REG_ADDR_W-1:0] rs2_addr;
  logic [XLEN-1:0]       rs1_data;
  logic [XLEN-1:0]       rs2_data;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic [XLEN-1:0]       rd_data;
  logic                  rd_we;
  logic [3:0]            alu_op;
  logic [XLEN-1:0]       alu_a;
  logic [XLEN-1:0]       alu_b;
  logic [XLEN-1:0]       alu_result;
  logic                  zero_flag;
  logic                  negative_flag;
  logic                  overflow_flag;

  modport master (
    output rs1_addr, rs2_addr, rd_addr, rd_data, rd_we, alu_op, alu_a, alu_b,
    input  rs1_data, rs2_data, alu_result, zero_flag, negative_flag, overflow_flag
  );

  modport slave (
    input  rs1_addr, rs2_addr, rd_addr, rd_data, rd_we, alu_op, alu_a, alu_b,
    output rs1_data, rs2_data, alu_result, zero_flag, negative_flag, overflow_flag
  );

endinterface

// File: rtl/rv32e_alu_regfile_alu.sv
// Purely combinational RV32 integer ALU. Unlisted codes with funct7[5]=1
// compute a-b so branch comparisons can be resolved from the flags.
module rv32e_alu_regfile_alu
  import rv32e_alu_regfile_pkg::*;
(
  input  logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_a,
  input  logic [XLEN-1:0] alu_b,
  output logic [XLEN-1:0] alu_result,
  output logic            zero_flag,
  output logic            negative_flag,
  output logic            overflow_flag
);

  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic [4:0]      shamt;
  logic            add_ovf;
  logic            sub_ovf;

  assign sum     = alu_a + alu_b;
  assign diff    = alu_a - alu_b;
  assign shamt   = alu_b[4:0];
  assign add_ovf = (alu_a[XLEN-1] == alu_b[XLEN-1]) && (sum[XLEN-1]  != alu_a[XLEN-1]);
  assign sub_ovf = (alu_a[XLEN-1] != alu_b[XLEN-1]) && (diff[XLEN-1] != alu_a[XLEN-1]);

  always_comb begin
    alu_result    = diff;
    overflow_flag = 1'b0;
    unique case (alu_op)
      ALU_ADD:  begin alu_result = sum; overflow_flag = add_ovf; end
      ALU_SLL:  alu_result = alu_a << shamt;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, alu_a < alu_b};
      ALU_XOR:  alu_result = alu_a ^ alu_b;
      ALU_SRL:  alu_result = alu_a >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(alu_a) >>> shamt);
      ALU_OR:   alu_result = alu_a | alu_b;
      ALU_AND:  alu_result = alu_a & alu_b;
      // SUB and every branch-compare code share the subtractor.
      default:  begin alu_result = diff; overflow_flag = sub_ovf; end
    endcase
  end

  assign zero_flag     = (alu_result == '0);
  assign negative_flag = alu_result[XLEN-1];

endmodule

// File: rtl/rv32e_alu_regfile_register.sv
// 16 x 32 register file: x0 hard-wired to zero, two combinational read ports
// with write-through bypass so a same-cycle WB write is seen by ID.
module rv32e_alu_regfile_register
  import rv32e_alu_regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]       rd_data,
  input  logic                  rd_we
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];
  logic            wr_en;

  assign wr_en = rd_we && (rd_addr != '0);

  // NOTE: regs_d starts as a copy of regs_q so every element is assigned on
  // every path; without that default this block would infer latches.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[rd_addr] = rd_data;
  end

  // NOTE: the array is reset here because software relies on all registers
  // reading zero after reset; a plain RAM without reset would not give that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [REG_ADDR_W-1:0] addr);
    if (addr == '0)                 return '0;
    else if (wr_en && addr == rd_addr) return rd_data;
    else                            return regs_q[addr];
  endfunction

  assign rs1_data = read_port(rs1_addr);
  assign rs2_data = read_port(rs2_addr);

endmodule

// File: rtl/rv32e_alu_regfile.sv
// Execute-stage datapath top: wires the register file and ALU to the bus.
module rv32e_alu_regfile (
  input  logic            clk,
  input  logic            rst_n,
  rv32e_alu_regfile_if.slave bus
);

  rv32e_alu_regfile_register u_register (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (bus.rs1_addr),
    .rs2_addr (bus.rs2_addr),
    .rs1_data (bus.rs1_data),
    .rs2_data (bus.rs2_data),
    .rd_addr  (bus.rd_addr),
    .rd_data  (bus.rd_data),
    .rd_we    (bus.rd_we)
  );

  rv32e_alu_regfile_alu u_alu (
    .alu_op        (bus.alu_op),
    .alu_a         (bus.alu_a),
    .alu_b         (bus.alu_b),
    .alu_result    (bus.alu_result),
    .zero_flag     (bus.zero_flag),
    .negative_flag (bus.negative_flag),
    .overflow_flag (bus.overflow_flag)
  );

endmodule

// File: tb/tb_rv32e_alu_regfile.sv
// Directed self-checking bench for rv32e_alu_regfile: reset, x0, bypass and
// hand-computed ALU vectors.
module tb_rv32e_alu_regfile;
  import rv32e_alu_regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  rv32e_alu_regfile_if bus_if ();

  rv32e_alu_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic write_reg(input logic [3:0] addr, input logic [31:0] data);
    bus_if.rd_addr = addr;
    bus_if.rd_data = data;
    bus_if.rd_we   = 1'b1;
    @(posedge clk);
    #1;
    bus_if.rd_we   = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] addr, input logic [31:0] expected);
    bus_if.rs1_addr = addr;
    bus_if.rs2_addr = addr;
    #1;
    check({tag, "_rs1"}, bus_if.rs1_data, expected);
    check({tag, "_rs2"}, bus_if.rs2_data, expected);
  endtask

  task automatic alu_check(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res,
                           input logic z, input logic n, input logic v);
    bus_if.alu_op = op;
    bus_if.alu_a  = a;
    bus_if.alu_b  = b;
    #1;
    check({tag, "_res"},  bus_if.alu_result, res);
    check({tag, "_zero"}, {31'b0, bus_if.zero_flag}, {31'b0, z});
    check({tag, "_neg"},  {31'b0, bus_if.negative_flag}, {31'b0, n});
    check({tag, "_ovf"},  {31'b0, bus_if.overflow_flag}, {31'b0, v});
  endtask

  initial begin
    rst_n           = 1'b0;
    bus_if.rs1_addr = '0;
    bus_if.rs2_addr = '0;
    bus_if.rd_addr  = '0;
    bus_if.rd_data  = '0;
    bus_if.rd_we    = 1'b0;
    bus_if.alu_op   = ALU_ADD;
    bus_if.alu_a    = '0;
    bus_if.alu_b    = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Fill some registers so the later mid-run reset has something to clear.
    for (int i = 1; i < 16; i++) write_reg(4'(i), 32'hA5A5_0000 | 32'(i));
    read_check("pre_reset_x7", 4'd7, 32'hA5A5_0007);

    // Reset asserted while a write to x3 is pending across an edge.
    bus_if.rd_addr = 4'd3;
    bus_if.rd_data = 32'h1111_2222;
    bus_if.rd_we   = 1'b1;
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 bus_if.rd_we = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) read_check($sformatf("reset_x%0d", i), 4'(i), 32'h0);

    // x0 ignores writes, including during the write cycle itself.
    bus_if.rd_addr  = 4'd0;
    bus_if.rd_data  = 32'hDEAD_BEEF;
    bus_if.rd_we    = 1'b1;
    bus_if.rs1_addr = 4'd0;
    #1 check("x0_during_write", bus_if.rs1_data, 32'h0);
    @(posedge clk);
    #1 bus_if.rd_we = 1'b0;
    read_check("x0_after_write", 4'd0, 32'h0);

    // Write-through bypass on x5, then stored value after the edge.
    bus_if.rd_addr  = 4'd5;
    bus_if.rd_data  = 32'h1234_5678;
    bus_if.rd_we    = 1'b1;
    bus_if.rs1_addr = 4'd5;
    bus_if.rs2_addr = 4'd5;
    #1;
    check("x5_bypass_rs1", bus_if.rs1_data, 32'h1234_5678);
    check("x5_bypass_rs2", bus_if.rs2_data, 32'h1234_5678);
    bus_if.rs2_addr = 4'd6;
    #1 check("x6_no_bypass", bus_if.rs2_data, 32'h0);
    @(posedge clk);
    #1 bus_if.rd_we = 1'b0;
    bus_if.rd_data  = 32'h0;
    read_check("x5_stored", 4'd5, 32'h1234_5678);
    read_check("x6_untouched", 4'd6, 32'h0);

    // ALU vectors:     tag        op        a             b             result        z     n     v
    alu_check("add_ovf",  ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b1);
    alu_check("add_wrap", ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0);
    alu_check("sub_zero", ALU_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0);
    alu_check("sub_ovf",  ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);
    alu_check("slt",      ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0);
    alu_check("sltu",     ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0);
    alu_check("xor",      ALU_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b1, 1'b0);
    alu_check("or",       ALU_OR,   32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b1, 1'b0);
    alu_check("and",      ALU_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0);
    alu_check("sll",      ALU_SLL,  32'h80000000, 32'h00000024, 32'h00000000, 1'b1, 1'b0, 1'b0);
    alu_check("srl",      ALU_SRL,  32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 1'b0, 1'b0);
    alu_check("sra",      ALU_SRA,  32'h80000000, 32'h00000024, 32'hF8000000, 1'b0, 1'b1, 1'b0);
    alu_check("sll_hi_b", ALU_SLL,  32'h00000001, 32'hFFFFFFE1, 32'h00000002, 1'b0, 1'b0, 1'b0);
    alu_check("bne",      BR_NE,    32'h00000003, 32'h00000007, 32'hFFFFFFFC, 1'b0, 1'b1, 1'b0);
    alu_check("bge_sra",  BR_GE,    32'h00000003, 32'h00000007, 32'h00000000, 1'b1, 1'b0, 1'b0);
    alu_check("bltu_ovf", BR_LTU,   32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);
    alu_check("op1010",   4'b1010,  32'h00000009, 32'h00000002, 32'h00000007, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
